hidden_layer_seq: RTL and testbench

Parametrised, time-multiplexed fully-connected layer engine; successor to the fixed 4-input `hidden_neuron` instances in the training datapath. Computes N_OUT neurons over N_IN shared inputs with one multiplier. Weights come from a writable register file (driven by the state machine / backprop path), not constants. Adds a start/busy/done handshake, selectable ReLU and output saturation; sits between the input pins and the output neuron.

---
 rtl/idann_pkg.sv | 32 +++
 rtl/layer_mac.sv | 54 +++++
 rtl/hidden_layer_seq.sv | 141 ++++++++++++++
 tb/tb_hidden_layer_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/idann_pkg.sv
// Shared types and arithmetic helpers for the layer engine and the output neuron.
package idann_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Accumulator width large enough that n_in full-scale products cannot overflow
  function automatic int acc_w(input int x_w, input int w_w, input int n_in);
    return x_w + w_w + 1 + $clog2(n_in);
  endfunction

  // ReLU: clamps negative values to zero when enabled
  function automatic logic signed [63:0] relu_f(input logic signed [63:0] v, input logic en);
    if (en && (v < 64'sd0)) return 64'sd0;
    return v;
  endfunction

  // Signed saturation to an out_w-bit two's complement range
  function automatic logic signed [63:0] sat_f(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/layer_mac.sv
// Single multiplier + accumulator with activation/saturation on the running sum.
module layer_mac
  import idann_pkg::*;
#(
  parameter int X_W   = 4,
  parameter int W_W   = 8,
  parameter int ACC_W = 15,
  parameter int OUT_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    mac_i,
  input  logic                    last_i,
  input  logic                    relu_i,
  input  logic [X_W-1:0]          x_i,
  input  logic signed [W_W-1:0]   w_i,
  output logic signed [OUT_W-1:0] y_o
);

  localparam int P_W = X_W + W_W + 1;

  logic signed [P_W-1:0]   w_x_ext;
  logic signed [P_W-1:0]   w_w_ext;
  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [63:0]      w_acc_ext;
  logic signed [63:0]      w_sat;
  logic                    w_unused_sat;
  logic signed [ACC_W-1:0] r_acc;

  // x is unsigned, so it is zero-extended before the signed multiply
  assign w_x_ext    = {{W_W{1'b0}}, x_i};
  assign w_w_ext    = {{(X_W + 1){w_i[W_W-1]}}, w_i};
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_acc_next = r_acc + {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};
  assign w_acc_ext  = {{(64 - ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
  assign w_sat      = sat_f(relu_f(w_acc_ext, relu_i), OUT_W);
  assign y_o        = w_sat[OUT_W-1:0];
  assign w_unused_sat = ^w_sat[63:OUT_W];

  // Accumulate one product per MAC cycle; restart at zero after each neuron
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc <= '0;
    end else if (en_i) begin
      if (clr_i)                r_acc <= '0;
      else if (mac_i && last_i) r_acc <= '0;
      else if (mac_i)           r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/hidden_layer_seq.sv
// Time-multiplexed fully-connected layer: FSM, counters, weight file, x latch, y bank.
module hidden_layer_seq
  import idann_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 8,
  parameter int X_W   = 4,
  parameter int W_W   = 8,
  parameter int OUT_W = 10
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              en_i,
  input  logic                              start_i,
  input  logic                              relu_i,
  input  logic [N_IN*X_W-1:0]               x_i,
  input  logic                              w_we_i,
  input  logic [$clog2(N_IN*N_OUT)-1:0]     w_addr_i,
  input  logic signed [W_W-1:0]             w_data_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              y_valid_o,
  output logic [N_OUT*OUT_W-1:0]            y_o
);

  localparam int NW    = N_IN * N_OUT;
  localparam int AW    = $clog2(NW);
  localparam int IW    = $clog2(N_IN);
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACC_W = acc_w(X_W, W_W, N_IN);

  state_t                  r_state;
  logic signed [W_W-1:0]   r_w [NW];
  logic [N_IN*X_W-1:0]     r_x;
  logic                    r_relu;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_y_valid;
  logic [N_OUT*OUT_W-1:0]  r_y;

  logic                    w_accept;
  logic                    w_mac;
  logic                    w_last_i;
  logic                    w_last_j;
  logic [AW-1:0]           w_idx;
  logic [X_W-1:0]          w_x_sel;
  logic signed [OUT_W-1:0] w_y;

  assign w_accept = (r_state == S_IDLE) && start_i;
  assign w_mac    = (r_state == S_MAC);
  assign w_last_i = (r_i == IW'(N_IN - 1));
  assign w_last_j = (r_j == JW'(N_OUT - 1));
  assign w_idx    = AW'(r_j * N_IN) + AW'(r_i);
  assign w_x_sel  = r_x[r_i*X_W +: X_W];

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign y_valid_o = r_y_valid;
  assign y_o       = r_y;

  // Weight file: writable only outside a pass so a pass sees constant weights
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NW; k++) r_w[k] <= '0;
    end else if (en_i && w_we_i && (r_state != S_MAC) && (int'(w_addr_i) < NW)) begin
      r_w[w_addr_i] <= w_data_i;
    end
  end

  layer_mac #(
    .X_W   (X_W),
    .W_W   (W_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .clr_i  (w_accept),
    .mac_i  (w_mac),
    .last_i (w_last_i),
    .relu_i (r_relu),
    .x_i    (w_x_sel),
    .w_i    (r_w[w_idx]),
    .y_o    (w_y)
  );

  // Sequencer: IDLE -> MAC (N_IN*N_OUT cycles) -> DONE -> IDLE, all outputs registered
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_relu    <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_y_valid <= 1'b0;
      r_y       <= '0;
    end else if (en_i) begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_x       <= x_i;
            r_relu    <= relu_i;
            r_i       <= '0;
            r_j       <= '0;
            r_y_valid <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (w_last_i) begin
            r_y[r_j*OUT_W +: OUT_W] <= w_y;
            r_i <= '0;
            if (w_last_j) begin
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_y_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq with default parameters (4 inputs, 8 neurons).
module tb_hidden_layer_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b1;
  logic               start = 1'b0;
  logic               relu = 1'b0;
  logic [15:0]        x = '0;
  logic               w_we = 1'b0;
  logic [4:0]         w_addr = '0;
  logic signed [7:0]  w_data = '0;
  logic               busy, done, y_valid;
  logic [79:0]        y;

  int n_cmp = 0;
  int n_err = 0;

  hidden_layer_seq dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .en_i      (en),
    .start_i   (start),
    .relu_i    (relu),
    .x_i       (x),
    .w_we_i    (w_we),
    .w_addr_i  (w_addr),
    .w_data_i  (w_data),
    .busy_o    (busy),
    .done_o    (done),
    .y_valid_o (y_valid),
    .y_o       (y)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int y_of(input int j);
    logic signed [9:0] v;
    v = y[j*10 +: 10];
    return int'(v);
  endfunction

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    w_we = 1'b1; w_addr = 5'(addr); w_data = 8'(data);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic write_all(input int data);
    for (int a = 0; a < 32; a++) write_w(a, data);
  endtask

  // n counts negedges after the accepting edge; done is expected at n = 32 (+ frozen cycles)
  task automatic run_pass(input logic [15:0] xv, input logic rv, input int inj_at,
                          input int en_at, input int en_len,
                          output int n_done, output int n_busy);
    int n;
    int nb;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x = xv; relu = rv;
    @(negedge clk);
    start = 1'b0;
    n = 0; nb = 0;
    chk_val("yvalid_clr_on_start", int'(y_valid), 0);
    while (!done && n < 200) begin
      if (busy) nb++;
      if (n == inj_at) begin
        start = 1'b1; w_we = 1'b1; w_addr = 5'd0; w_data = 8'sd99;
      end
      if (n == en_at) en = 1'b0;
      if (en_at >= 0 && n == en_at + en_len) en = 1'b1;
      @(negedge clk);
      n++;
      start = 1'b0; w_we = 1'b0;
    end
    if (n >= 200) chk_val("pass_timeout", 0, 1);
    n_done = n;
    n_busy = nb;
  endtask

  initial begin
    int nd, nbz;

    #12;
    chk_val("rst_busy", int'(busy), 0);
    chk_val("rst_done", int'(done), 0);
    chk_val("rst_yvalid", int'(y_valid), 0);
    chk_val("rst_y0", y_of(0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all weights 1, x = 15 each, relu: 4*15 = 60
    write_all(1);
    run_pass(16'hFFFF, 1'b1, -1, -1, 0, nd, nbz);
    chk_val("t1_done_edges", nd, 32);
    chk_val("t1_busy_cycles", nbz, 32);
    chk_val("t1_yvalid", int'(y_valid), 1);
    for (int j = 0; j < 8; j++) chk_val($sformatf("t1_y%0d", j), y_of(j), 60);

    // all weights 127: 7620 saturates to 511
    write_all(127);
    run_pass(16'hFFFF, 1'b0, -1, -1, 0, nd, nbz);
    chk_val("t2_y0", y_of(0), 511);
    chk_val("t2_y7", y_of(7), 511);

    // all weights -128: -7680 saturates to -512, or 0 under ReLU
    write_all(-128);
    run_pass(16'hFFFF, 1'b0, -1, -1, 0, nd, nbz);
    chk_val("t3_y0_norelu", y_of(0), -512);
    chk_val("t3_y5_norelu", y_of(5), -512);
    run_pass(16'hFFFF, 1'b1, -1, -1, 0, nd, nbz);
    chk_val("t3_y0_relu", y_of(0), 0);
    chk_val("t3_y7_relu", y_of(7), 0);

    // neuron j weights = j+1, x = {1,2,3,4}: y[j] = 10*(j+1); mid-pass start/write ignored
    for (int jj = 0; jj < 8; jj++)
      for (int ii = 0; ii < 4; ii++) write_w(jj*4 + ii, jj + 1);
    run_pass(16'h4321, 1'b0, 2, -1, 0, nd, nbz);
    chk_val("t4_done_edges", nd, 32);
    chk_val("t4_busy_cycles", nbz, 32);
    for (int j = 0; j < 8; j++) chk_val($sformatf("t4_y%0d", j), y_of(j), 10*(j+1));
    @(negedge clk);
    @(negedge clk);
    chk_val("t4_no_queued_start", int'(busy), 0);

    // en low for 5 cycles mid-pass; also shows the earlier mid-pass write of w[0] was dropped
    run_pass(16'h4321, 1'b0, -1, 10, 5, nd, nbz);
    chk_val("t5_done_edges", nd, 37);
    chk_val("t5_busy_cycles", nbz, 37);
    chk_val("t5_y0", y_of(0), 10);
    chk_val("t5_y3", y_of(3), 40);
    chk_val("t5_y7", y_of(7), 80);

    // reset at MAC cycle 10
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; x = 16'hFFFF; relu = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk_val("t6_busy_before_rst", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_val("t6_rst_busy", int'(busy), 0);
    chk_val("t6_rst_yvalid", int'(y_valid), 0);
    chk_val("t6_rst_y0", y_of(0), 0);
    chk_val("t6_rst_y7", y_of(7), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(16'hFFFF, 1'b0, -1, -1, 0, nd, nbz);
    chk_val("t6_done_edges", nd, 32);
    chk_val("t6_w_cleared_y0", y_of(0), 0);
    chk_val("t6_w_cleared_y6", y_of(6), 0);
    chk_val("t6_yvalid", int'(y_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
